// File: rtl/clk_pkg.sv
// Shared encodings for the clock front panel: display modes, edit fields and
// the VIEW/EDIT sequencer state.
package clk_pkg;

   localparam logic [2:0] MODE_CLOCK     = 3'd1;
   localparam logic [2:0] MODE_ALARM     = 3'd2;
   localparam logic [2:0] MODE_STOPWATCH = 3'd3;
   localparam logic [2:0] MODE_TIMER     = 3'd4;

   localparam logic [1:0] FLD_HOUR = 2'd0;
   localparam logic [1:0] FLD_MIN  = 2'd1;
   localparam logic [1:0] FLD_SEC  = 2'd2;

   typedef enum logic {
      VIEW = 1'b0,
      EDIT = 1'b1
   } state_t;

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-flop synchronizer, debounce counter and a
// single-cycle pulse on each accepted rising level.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          deb_q, deb_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;

   // The counter only runs while the synchronized level disagrees with the
   // accepted level; any agreement restarts the stability window.
   always_comb begin
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      press_d = 1'b0;
      if (sync2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         deb_d   = sync2_q;
         cnt_d   = '0;
         press_d = sync2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         cnt_q   <= '0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/mode_sequencer.sv
// Front-panel controller: debounced up/down/set buttons drive the display
// mode, the per-mode field edit sequence and the datapath strobes.
module mode_sequencer
   import clk_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_set,
   output logic [2:0] mode,
   output logic       edit,
   output logic [1:0] field,
   output logic       inc,
   output logic       dec,
   output logic       ss_toggle
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic upPress, downPress, setPress;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) upDeb_u (
      .clk(clk), .rst(rst), .btn_i(btn_up), .press_o(upPress)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) downDeb_u (
      .clk(clk), .rst(rst), .btn_i(btn_down), .press_o(downPress)
   );
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) setDeb_u (
      .clk(clk), .rst(rst), .btn_i(btn_set), .press_o(setPress)
   );

   state_t        state_q, state_d;
   logic [2:0]    mode_q, mode_d;
   logic [1:0]    field_q, field_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          inc_q, inc_d;
   logic          dec_q, dec_d;
   logic          ss_q, ss_d;

   // Set always takes priority; up and down together cancel each other but
   // still count as activity for the edit timeout.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      field_d = field_q;
      tmo_d   = tmo_q;
      inc_d   = 1'b0;
      dec_d   = 1'b0;
      ss_d    = 1'b0;
      case (state_q)
         VIEW: begin
            if (setPress) begin
               if (mode_q == MODE_STOPWATCH) begin
                  ss_d = 1'b1;
               end else begin
                  state_d = EDIT;
                  field_d = FLD_HOUR;
                  tmo_d   = '0;
               end
            end else if (upPress && !downPress) begin
               mode_d = (mode_q == MODE_TIMER) ? MODE_CLOCK : mode_q + 3'd1;
            end else if (downPress && !upPress) begin
               mode_d = (mode_q == MODE_CLOCK) ? MODE_TIMER : mode_q - 3'd1;
            end
         end
         EDIT: begin
            if (setPress) begin
               tmo_d = '0;
               if (field_q == FLD_SEC) begin
                  state_d = VIEW;
                  field_d = FLD_HOUR;
               end else begin
                  field_d = field_q + 2'd1;
               end
            end else if (upPress || downPress) begin
               tmo_d = '0;
               inc_d = upPress && !downPress;
               dec_d = downPress && !upPress;
            end else if (tmo_q == TMO_LAST) begin
               state_d = VIEW;
               field_d = FLD_HOUR;
               tmo_d   = '0;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: begin
            state_d = VIEW;
            field_d = FLD_HOUR;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= VIEW;
         mode_q  <= MODE_CLOCK;
         field_q <= FLD_HOUR;
         tmo_q   <= '0;
         inc_q   <= 1'b0;
         dec_q   <= 1'b0;
         ss_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         field_q <= field_d;
         tmo_q   <= tmo_d;
         inc_q   <= inc_d;
         dec_q   <= dec_d;
         ss_q    <= ss_d;
      end
   end

   assign mode      = mode_q;
   assign edit      = (state_q == EDIT);
   assign field     = field_q;
   assign inc       = inc_q;
   assign dec       = dec_q;
   assign ss_toggle = ss_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: directed panel scenarios plus random button
// traffic, every cycle compared against a behavioural model of the panel.
module tb_mode_sequencer;

   localparam int DEB = 4;
   localparam int TMO = 16;

   logic       clk;
   logic       rst;
   logic       btnUp, btnDown, btnSet;
   logic [2:0] mode;
   logic       edit;
   logic [1:0] field;
   logic       inc, dec, ssToggle;

   int checks = 0;
   int passes = 0;

   // Model state: plain integers for the panel, per-button sample history.
   int       mMode = 1, mField = 0, mTmo = 0;
   bit       mEdit = 0, mInc = 0, mDec = 0, mSs = 0;
   bit [2:0] mS1 = '0, mS2 = '0, mDeb = '0, mPress = '0;
   int       mRun[3] = '{0, 0, 0};

   int incCount = 0, decCount = 0, ssCount = 0;

   mode_sequencer #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .btn_up(btnUp), .btn_down(btnDown), .btn_set(btnSet),
      .mode(mode), .edit(edit), .field(field),
      .inc(inc), .dec(dec), .ss_toggle(ssToggle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed == expected) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   // Panel behaviour: a button counts as pressed once its sampled level has
   // disagreed with the accepted level for DEB cycles in a row.
   task automatic modelStep();
      bit [2:0] raw;
      bit pu, pd, ps;
      raw = {btnSet, btnDown, btnUp};
      if (rst) begin
         mMode = 1; mEdit = 0; mField = 0; mTmo = 0;
         mInc = 0; mDec = 0; mSs = 0;
         mS1 = '0; mS2 = '0; mDeb = '0; mPress = '0;
         for (int b = 0; b < 3; b++) mRun[b] = 0;
         return;
      end
      pu = mPress[0]; pd = mPress[1]; ps = mPress[2];
      mInc = 0; mDec = 0; mSs = 0;
      if (!mEdit) begin
         if (ps) begin
            if (mMode == 3) mSs = 1;
            else begin mEdit = 1; mField = 0; mTmo = 0; end
         end else if (pu && !pd) mMode = (mMode % 4) + 1;
         else if (pd && !pu) mMode = (mMode == 1) ? 4 : mMode - 1;
      end else begin
         if (ps) begin
            mTmo = 0;
            if (mField == 2) begin mEdit = 0; mField = 0; end
            else mField++;
         end else if (pu || pd) begin
            mTmo = 0;
            mInc = pu && !pd;
            mDec = pd && !pu;
         end else if (mTmo == TMO - 1) begin
            mEdit = 0; mField = 0; mTmo = 0;
         end else mTmo++;
      end
      for (int b = 0; b < 3; b++) begin
         mPress[b] = 1'b0;
         if (mS2[b] != mDeb[b]) begin
            mRun[b]++;
            if (mRun[b] == DEB) begin
               mDeb[b]   = mS2[b];
               mRun[b]   = 0;
               mPress[b] = mDeb[b];
            end
         end else mRun[b] = 0;
      end
      mS2 = mS1;
      mS1 = raw;
   endtask

   always @(posedge clk or posedge rst) modelStep();

   always @(negedge clk) begin
      checkOutput("mode", int'(mode), mMode);
      checkOutput("edit", int'(edit), int'(mEdit));
      checkOutput("field", int'(field), mField);
      checkOutput("inc", int'(inc), int'(mInc));
      checkOutput("dec", int'(dec), int'(mDec));
      checkOutput("ss_toggle", int'(ssToggle), int'(mSs));
      checkOutput("oneStrobe", ((int'(inc) + int'(dec) + int'(ssToggle)) <= 1) ? 1 : 0, 1);
      incCount += int'(inc);
      decCount += int'(dec);
      ssCount  += int'(ssToggle);
   end

   task automatic applyStimulus(input bit u, input bit d, input bit s, input int hold);
      @(posedge clk); #1;
      btnUp = u; btnDown = d; btnSet = s;
      repeat (hold) @(posedge clk);
      #1;
      btnUp = 1'b0; btnDown = 1'b0; btnSet = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      int incBase, decBase, ssBase;
      rst = 1'b1; btnUp = 1'b0; btnDown = 1'b0; btnSet = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("resetMode", int'(mode), 1);
      checkOutput("resetEdit", int'(edit), 0);
      checkOutput("resetField", int'(field), 0);
      checkOutput("resetStrobes", int'(inc) + int'(dec) + int'(ssToggle), 0);

      // Up press latency from the edge the raw level first becomes stable.
      @(posedge clk); #1 btnUp = 1'b1;
      lat = 0;
      for (int k = 1; k <= 15; k++) begin
         @(posedge clk); #1;
         if (mode == 3'd2 && lat == 0) lat = k;
      end
      btnUp = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      checkOutput("upLatency", lat, DEB + 3);
      checkOutput("upOnce", int'(mode), 2);
      applyStimulus(1, 0, 0, 10); checkOutput("upTo3", int'(mode), 3);
      applyStimulus(1, 0, 0, 10); checkOutput("upTo4", int'(mode), 4);
      applyStimulus(1, 0, 0, 10); checkOutput("upWrap1", int'(mode), 1);
      applyStimulus(0, 1, 0, 10); checkOutput("downWrap4", int'(mode), 4);
      applyStimulus(0, 1, 0, 2);  checkOutput("glitchIgnored", int'(mode), 4);
      applyStimulus(1, 0, 0, 5);  checkOutput("backTo1", int'(mode), 1);

      // Edit sequence in CLOCK mode.
      incBase = incCount; decBase = decCount;
      applyStimulus(0, 0, 1, 5);
      checkOutput("enterEdit", int'(edit), 1);
      checkOutput("enterField", int'(field), 0);
      applyStimulus(1, 0, 0, 5);
      applyStimulus(1, 0, 0, 5);
      applyStimulus(0, 1, 0, 5);
      checkOutput("incCount", incCount - incBase, 2);
      checkOutput("decCount", decCount - decBase, 1);
      checkOutput("editHeld", int'(edit), 1);
      applyStimulus(0, 0, 1, 5); checkOutput("field1", int'(field), 1);
      applyStimulus(0, 0, 1, 5); checkOutput("field2", int'(field), 2);
      applyStimulus(0, 0, 1, 5);
      checkOutput("exitEdit", int'(edit), 0);
      checkOutput("exitField", int'(field), 0);
      checkOutput("editModeKept", int'(mode), 1);

      // Stopwatch start/stop and cancelling up+down.
      applyStimulus(1, 0, 0, 5);
      applyStimulus(1, 0, 0, 5);
      ssBase = ssCount;
      applyStimulus(0, 0, 1, 5);
      checkOutput("ssPulse", ssCount - ssBase, 1);
      checkOutput("ssNoEdit", int'(edit), 0);
      applyStimulus(1, 1, 0, 5);
      checkOutput("upDownMode", int'(mode), 3);

      // Edit timeout in ALARM mode.
      applyStimulus(0, 1, 0, 5);
      incBase = incCount; decBase = decCount;
      applyStimulus(0, 0, 1, 5);
      checkOutput("alarmEdit", int'(edit), 1);
      repeat (30) @(posedge clk);
      #1;
      checkOutput("timeoutEdit", int'(edit), 0);
      checkOutput("timeoutField", int'(field), 0);
      checkOutput("timeoutNoStrobe", (incCount - incBase) + (decCount - decBase), 0);

      // Asynchronous reset in the middle of an edit, with up held through it.
      applyStimulus(0, 1, 0, 5);
      applyStimulus(0, 0, 1, 5);
      applyStimulus(0, 0, 1, 5);
      checkOutput("preResetField", int'(field), 1);
      @(posedge clk); #3;
      rst = 1'b1; btnUp = 1'b1;
      #1;
      checkOutput("asyncMode", int'(mode), 1);
      checkOutput("asyncEdit", int'(edit), 0);
      checkOutput("asyncField", int'(field), 0);
      checkOutput("asyncStrobes", int'(inc) + int'(dec) + int'(ssToggle), 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("heldThroughReset", int'(mode), 2);
      btnUp = 1'b0;
      repeat (10) @(posedge clk);
      #1;

      // Random button traffic against the model.
      for (int i = 0; i < 250; i++) begin
         btnUp   = ($urandom_range(0, 3) == 0);
         btnDown = ($urandom_range(0, 3) == 0);
         btnSet  = ($urandom_range(0, 4) == 0);
         repeat ($urandom_range(1, 8)) @(posedge clk);
         #1;
         btnUp = 1'b0; btnDown = 1'b0; btnSet = 1'b0;
         repeat ($urandom_range(0, 12)) @(posedge clk);
         #1;
      end
      repeat (20) @(posedge clk);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
